// File: rtl/asrm_ram_arbiter.sv
// -----------------------------------------------------------------------------
// asrm_ram_arbiter
//
// Shares the single RAM port between the CPU memory interface ("cpu") and an
// auxiliary master ("aux", e.g. DMA or a debug loader). Each access moves
// through a three-state sequencer:
//   IDLE   : waits for a request, picks a winner and latches its command.
//   ACCESS : drives the latched address/data to the RAM for ram_latency
//            cycles (reads) or exactly one cycle (writes).
//   DONE   : pulses the owner's acknowledge for a single cycle.
//
// Read data is registered into the owner's rdata register. That register is
// held until the next read completed for the same port.
//
// Configuration macro:
//   ASRM_ARB_ROUND_ROBIN_EN
//     defined   : ties between cpu and aux alternate, using a last-grant bit.
//                 After reset the bit points at aux, so the cpu wins the
//                 first tie.
//     undefined : fixed priority. The cpu wins every tie.
//
// Parameters:
//   wordsize    : width of the address and data buses
//   ram_latency : cycles from address presented to ram_data_in valid (1..15)
//
// Ports:
//   clk, reset                   : clock, synchronous active-high reset
//   cpu_req / aux_req            : level request, held until the matching ack
//   cpu_write_en / aux_write_en  : 1 = write, 0 = read
//   cpu_addr / aux_addr          : access address
//   cpu_wdata / aux_wdata        : write data
//   cpu_rdata / aux_rdata        : registered read data
//   cpu_ack / aux_ack            : one-cycle completion pulse
//   ram_addr, ram_data_out       : RAM address and write data
//   ram_data_in                  : RAM read data
//   ram_write_en                 : RAM write strobe
//   busy                         : high whenever the sequencer is not in IDLE
//   owner                        : 0 = cpu, 1 = aux. Owner of the current or
//                                  last access.
// -----------------------------------------------------------------------------
module asrm_ram_arbiter #(
  parameter int wordsize    = 16,
  parameter int ram_latency = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                cpu_req,
  input  logic                cpu_write_en,
  input  logic [wordsize-1:0] cpu_addr,
  input  logic [wordsize-1:0] cpu_wdata,
  output logic [wordsize-1:0] cpu_rdata,
  output logic                cpu_ack,
  input  logic                aux_req,
  input  logic                aux_write_en,
  input  logic [wordsize-1:0] aux_addr,
  input  logic [wordsize-1:0] aux_wdata,
  output logic [wordsize-1:0] aux_rdata,
  output logic                aux_ack,
  output logic [wordsize-1:0] ram_addr,
  output logic [wordsize-1:0] ram_data_out,
  input  logic [wordsize-1:0] ram_data_in,
  output logic                ram_write_en,
  output logic                busy,
  output logic                owner
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  // Counter load values: a read waits out the RAM latency, and a write needs
  // only the single strobe cycle.
  localparam logic [3:0]          LAT_CNT = 4'(ram_latency);
  localparam logic [3:0]          WR_CNT  = 4'd1;
  localparam logic [wordsize-1:0] ZERO_W  = {wordsize{1'b0}};

  // Sequencer state and latched command
  state_t              state_r, state_s;
  logic [3:0]          cnt_r, cnt_s;
  logic                lat_we_r, lat_we_s;
  logic [wordsize-1:0] lat_addr_r, lat_addr_s;
  logic [wordsize-1:0] lat_wdata_r, lat_wdata_s;
  logic                owner_r, owner_s;

  // Registered outputs
  logic [wordsize-1:0] cpu_rdata_r, cpu_rdata_s;
  logic [wordsize-1:0] aux_rdata_r, aux_rdata_s;
  logic                cpu_ack_r, cpu_ack_s;
  logic                aux_ack_r, aux_ack_s;
  logic [wordsize-1:0] ram_addr_r, ram_addr_s;
  logic [wordsize-1:0] ram_data_out_r, ram_data_out_s;
  logic                ram_we_r, ram_we_s;
  logic                busy_r, busy_s;

  // Arbitration
  logic                start_s;
  logic                grant_aux_s;

  // A new access starts whenever IDLE sees any request
  always_comb begin
    start_s = 1'b0;
    if ((state_r == ST_IDLE) && (cpu_req || aux_req)) begin
      start_s = 1'b1;
    end else begin
      start_s = 1'b0;
    end
  end

`ifdef ASRM_ARB_ROUND_ROBIN_EN
  logic last_grant_r;

  // Round-robin winner selection: on a tie, grant the port not served last
  always_comb begin
    grant_aux_s = 1'b0;
    if (cpu_req && aux_req) begin
      grant_aux_s = ~last_grant_r;
    end else if (aux_req) begin
      grant_aux_s = 1'b1;
    end else begin
      grant_aux_s = 1'b0;
    end
  end

  // Last-grant bit: resets to aux so the cpu takes the first tie
  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant_r <= 1'b1;
    end else if (start_s) begin
      last_grant_r <= grant_aux_s;
    end else begin
      last_grant_r <= last_grant_r;
    end
  end
`else
  // Fixed-priority winner selection: aux only when the cpu is not asking
  always_comb begin
    grant_aux_s = 1'b0;
    if (cpu_req) begin
      grant_aux_s = 1'b0;
    end else if (aux_req) begin
      grant_aux_s = 1'b1;
    end else begin
      grant_aux_s = 1'b0;
    end
  end
`endif

  // Next-state, command latch, latency counter and read-data capture
  always_comb begin
    state_s     = state_r;
    cnt_s       = cnt_r;
    lat_we_s    = lat_we_r;
    lat_addr_s  = lat_addr_r;
    lat_wdata_s = lat_wdata_r;
    owner_s     = owner_r;
    cpu_rdata_s = cpu_rdata_r;
    aux_rdata_s = aux_rdata_r;
    case (state_r)
      ST_IDLE: begin
        if (start_s) begin
          owner_s = grant_aux_s;
          if (grant_aux_s) begin
            lat_we_s    = aux_write_en;
            lat_addr_s  = aux_addr;
            lat_wdata_s = aux_wdata;
          end else begin
            lat_we_s    = cpu_write_en;
            lat_addr_s  = cpu_addr;
            lat_wdata_s = cpu_wdata;
          end
          if (lat_we_s) begin
            cnt_s = WR_CNT;
          end else begin
            cnt_s = LAT_CNT;
          end
          state_s = ST_ACCESS;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_ACCESS: begin
        // The "<=" also treats a zero count as finished, so a corrupted
        // counter can never leave the sequencer stuck in ACCESS.
        if (cnt_r <= 4'd1) begin
          cnt_s = 4'd0;
          if (!lat_we_r) begin
            if (owner_r) begin
              aux_rdata_s = ram_data_in;
            end else begin
              cpu_rdata_s = ram_data_in;
            end
          end else begin
            cpu_rdata_s = cpu_rdata_r;
          end
          state_s = ST_DONE;
        end else begin
          cnt_s   = cnt_r - 4'd1;
          state_s = ST_ACCESS;
        end
      end
      ST_DONE: begin
        state_s = ST_IDLE;
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // Output values for the coming cycle, decoded from the next state
  always_comb begin
    ram_addr_s     = ZERO_W;
    ram_data_out_s = ZERO_W;
    ram_we_s       = 1'b0;
    cpu_ack_s      = 1'b0;
    aux_ack_s      = 1'b0;
    busy_s         = 1'b0;
    if (state_s == ST_ACCESS) begin
      ram_addr_s     = lat_addr_s;
      ram_data_out_s = lat_wdata_s;
      ram_we_s       = lat_we_s;
    end else begin
      ram_addr_s     = ZERO_W;
      ram_data_out_s = ZERO_W;
      ram_we_s       = 1'b0;
    end
    if (state_s == ST_DONE) begin
      cpu_ack_s = ~owner_s;
      aux_ack_s = owner_s;
    end else begin
      cpu_ack_s = 1'b0;
      aux_ack_s = 1'b0;
    end
    if (state_s != ST_IDLE) begin
      busy_s = 1'b1;
    end else begin
      busy_s = 1'b0;
    end
  end

  // State, latch and output registers; reset aborts any access in flight
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r        <= ST_IDLE;
      cnt_r          <= 4'd0;
      lat_we_r       <= 1'b0;
      lat_addr_r     <= ZERO_W;
      lat_wdata_r    <= ZERO_W;
      owner_r        <= 1'b0;
      cpu_rdata_r    <= ZERO_W;
      aux_rdata_r    <= ZERO_W;
      cpu_ack_r      <= 1'b0;
      aux_ack_r      <= 1'b0;
      ram_addr_r     <= ZERO_W;
      ram_data_out_r <= ZERO_W;
      ram_we_r       <= 1'b0;
      busy_r         <= 1'b0;
    end else begin
      state_r        <= state_s;
      cnt_r          <= cnt_s;
      lat_we_r       <= lat_we_s;
      lat_addr_r     <= lat_addr_s;
      lat_wdata_r    <= lat_wdata_s;
      owner_r        <= owner_s;
      cpu_rdata_r    <= cpu_rdata_s;
      aux_rdata_r    <= aux_rdata_s;
      cpu_ack_r      <= cpu_ack_s;
      aux_ack_r      <= aux_ack_s;
      ram_addr_r     <= ram_addr_s;
      ram_data_out_r <= ram_data_out_s;
      ram_we_r       <= ram_we_s;
      busy_r         <= busy_s;
    end
  end

  assign cpu_rdata    = cpu_rdata_r;
  assign aux_rdata    = aux_rdata_r;
  assign cpu_ack      = cpu_ack_r;
  assign aux_ack      = aux_ack_r;
  assign ram_addr     = ram_addr_r;
  assign ram_data_out = ram_data_out_r;
  assign ram_write_en = ram_we_r;
  assign busy         = busy_r;
  assign owner        = owner_r;

endmodule

// File: tb/tb_asrm_ram_arbiter.sv
// -----------------------------------------------------------------------------
// tb_asrm_ram_arbiter
//
// Directed bench for asrm_ram_arbiter. It uses two instances:
//   dut_a : ram_latency = 1, backed by a small word-addressed RAM model.
//           The model is reloaded while reset is high, with 0xBEEF at 0x0010.
//   dut_b : ram_latency = 3. ram_data_in is driven directly, which controls
//           exactly which cycle carries valid data.
//
// Inputs are driven and outputs sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_asrm_ram_arbiter;

  localparam int W = 16;

  logic clk = 1'b0;
  logic reset;

  // Clock generator
  always #5 clk = ~clk;

  // dut_a signals
  logic         a_cpu_req, a_cpu_write_en, a_cpu_ack;
  logic [W-1:0] a_cpu_addr, a_cpu_wdata, a_cpu_rdata;
  logic         a_aux_req, a_aux_write_en, a_aux_ack;
  logic [W-1:0] a_aux_addr, a_aux_wdata, a_aux_rdata;
  logic [W-1:0] a_ram_addr, a_ram_data_out, a_ram_data_in;
  logic         a_ram_write_en, a_busy, a_owner;

  // dut_b signals
  logic         b_cpu_req, b_cpu_write_en, b_cpu_ack;
  logic [W-1:0] b_cpu_addr, b_cpu_wdata, b_cpu_rdata;
  logic         b_aux_req, b_aux_write_en, b_aux_ack;
  logic [W-1:0] b_aux_addr, b_aux_wdata, b_aux_rdata;
  logic [W-1:0] b_ram_addr, b_ram_data_out, b_ram_data_in;
  logic         b_ram_write_en, b_busy, b_owner;

  asrm_ram_arbiter #(.wordsize(W), .ram_latency(1)) dut_a (
    .clk(clk), .reset(reset),
    .cpu_req(a_cpu_req), .cpu_write_en(a_cpu_write_en), .cpu_addr(a_cpu_addr),
    .cpu_wdata(a_cpu_wdata), .cpu_rdata(a_cpu_rdata), .cpu_ack(a_cpu_ack),
    .aux_req(a_aux_req), .aux_write_en(a_aux_write_en), .aux_addr(a_aux_addr),
    .aux_wdata(a_aux_wdata), .aux_rdata(a_aux_rdata), .aux_ack(a_aux_ack),
    .ram_addr(a_ram_addr), .ram_data_out(a_ram_data_out), .ram_data_in(a_ram_data_in),
    .ram_write_en(a_ram_write_en), .busy(a_busy), .owner(a_owner)
  );

  asrm_ram_arbiter #(.wordsize(W), .ram_latency(3)) dut_b (
    .clk(clk), .reset(reset),
    .cpu_req(b_cpu_req), .cpu_write_en(b_cpu_write_en), .cpu_addr(b_cpu_addr),
    .cpu_wdata(b_cpu_wdata), .cpu_rdata(b_cpu_rdata), .cpu_ack(b_cpu_ack),
    .aux_req(b_aux_req), .aux_write_en(b_aux_write_en), .aux_addr(b_aux_addr),
    .aux_wdata(b_aux_wdata), .aux_rdata(b_aux_rdata), .aux_ack(b_aux_ack),
    .ram_addr(b_ram_addr), .ram_data_out(b_ram_data_out), .ram_data_in(b_ram_data_in),
    .ram_write_en(b_ram_write_en), .busy(b_busy), .owner(b_owner)
  );

  // RAM model for dut_a: combinational read, write on the strobe edge
  logic [W-1:0] mem [0:1023];

  // Memory contents: reloaded while reset is high, written by dut_a strobes
  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 1024; i++) mem[i] <= 16'h0000;
      mem[16] <= 16'hBEEF;
    end else if (a_ram_write_en) begin
      mem[a_ram_addr[9:0]] <= a_ram_data_out;
    end
  end

  assign a_ram_data_in = mem[a_ram_addr[9:0]];

  int check_cnt = 0;
  int err_cnt   = 0;

  task automatic chk_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    check_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Waits, with a bound, for the next ack from dut_a.
  // who: 0 = cpu ack, 1 = aux ack, 2 = no ack before the bound.
  task automatic wait_ack_a(output int who);
    who = 2;
    for (int i = 0; i < 12 && who == 2; i++) begin
      @(negedge clk);
      if (a_cpu_ack) who = 0;
      else if (a_aux_ack) who = 1;
    end
  endtask

  // Guard against a hung run
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  // Directed stimulus
  initial begin
    int who;
    int exp_who;
    int n;
    int drop_at;

    reset = 1'b1;
    a_cpu_req = 1'b0; a_cpu_write_en = 1'b0; a_cpu_addr = 16'h0000; a_cpu_wdata = 16'h0000;
    a_aux_req = 1'b0; a_aux_write_en = 1'b0; a_aux_addr = 16'h0000; a_aux_wdata = 16'h0000;
    b_cpu_req = 1'b0; b_cpu_write_en = 1'b0; b_cpu_addr = 16'h0000; b_cpu_wdata = 16'h0000;
    b_aux_req = 1'b0; b_aux_write_en = 1'b0; b_aux_addr = 16'h0000; b_aux_wdata = 16'h0000;
    b_ram_data_in = 16'h0000;

    repeat (3) @(negedge clk);
    chk_val("rst_busy", a_busy, 1'b0);
    chk_val("rst_acks", {a_cpu_ack, a_aux_ack}, 2'b00);
    chk_val("rst_ram_we", a_ram_write_en, 1'b0);
    chk_val("rst_ram_addr", a_ram_addr, 16'h0000);
    chk_val("rst_ram_dout", a_ram_data_out, 16'h0000);
    chk_val("rst_rdata", {a_cpu_rdata, a_aux_rdata}, 32'h0);
    chk_val("rst_owner", a_owner, 1'b0);
    chk_val("rst_b_busy", b_busy, 1'b0);
    reset = 1'b0;

    // CPU read at 0x0010 with ram_latency 1
    a_cpu_addr = 16'h0010; a_cpu_write_en = 1'b0; a_cpu_req = 1'b1;
    @(negedge clk);
    chk_val("rd_addr", a_ram_addr, 16'h0010);
    chk_val("rd_busy", a_busy, 1'b1);
    chk_val("rd_ack_early", a_cpu_ack, 1'b0);
    @(negedge clk);
    chk_val("rd_ack", a_cpu_ack, 1'b1);
    chk_val("rd_rdata", a_cpu_rdata, 16'hBEEF);
    chk_val("rd_addr_done", a_ram_addr, 16'h0000);
    a_cpu_req = 1'b0;
    @(negedge clk);
    chk_val("rd_ack_pulse", a_cpu_ack, 1'b0);
    chk_val("rd_rdata_hold", a_cpu_rdata, 16'hBEEF);
    chk_val("rd_aux_rdata", a_aux_rdata, 16'h0000);
    chk_val("rd_idle", a_busy, 1'b0);

    // Aux write of 0x1234 to 0x0100
    a_aux_addr = 16'h0100; a_aux_wdata = 16'h1234; a_aux_write_en = 1'b1; a_aux_req = 1'b1;
    @(negedge clk);
    chk_val("wr_we", a_ram_write_en, 1'b1);
    chk_val("wr_addr", a_ram_addr, 16'h0100);
    chk_val("wr_dout", a_ram_data_out, 16'h1234);
    chk_val("wr_owner", a_owner, 1'b1);
    chk_val("wr_ack_early", a_aux_ack, 1'b0);
    @(negedge clk);
    chk_val("wr_we_drop", a_ram_write_en, 1'b0);
    chk_val("wr_ack", {a_cpu_ack, a_aux_ack}, 2'b01);
    a_aux_req = 1'b0; a_aux_write_en = 1'b0;
    @(negedge clk);
    chk_val("wr_ack_pulse", a_aux_ack, 1'b0);
    chk_val("wr_cpu_rdata", a_cpu_rdata, 16'hBEEF);
    chk_val("wr_aux_rdata", a_aux_rdata, 16'h0000);
    chk_val("wr_owner_hold", a_owner, 1'b1);

    // Simultaneous held reads: cpu at 0x0010, aux at 0x0100
    a_cpu_addr = 16'h0010; a_aux_addr = 16'h0100;
    a_cpu_req = 1'b1; a_aux_req = 1'b1;
    for (int g = 0; g < 4; g++) begin
`ifdef ASRM_ARB_ROUND_ROBIN_EN
      exp_who = g % 2;
`else
      exp_who = 0;
`endif
      wait_ack_a(who);
      chk_val($sformatf("tie_grant%0d", g), who, exp_who);
    end
    a_cpu_req = 1'b0;
    wait_ack_a(who);
    chk_val("tie_aux_served", who, 1);
    chk_val("tie_aux_rdata", a_aux_rdata, 16'h1234);
    chk_val("tie_cpu_rdata", a_cpu_rdata, 16'hBEEF);
    a_aux_req = 1'b0;
    repeat (2) @(negedge clk);
    chk_val("tie_idle", a_busy, 1'b0);

    // ram_latency 3 read of 0x0020; only the third-cycle data is valid
    b_ram_data_in = 16'h0055; b_cpu_addr = 16'h0020; b_cpu_req = 1'b1;
    @(negedge clk);
    chk_val("l3_addr1", b_ram_addr, 16'h0020);
    chk_val("l3_ack1", b_cpu_ack, 1'b0);
    @(negedge clk);
    chk_val("l3_addr2", b_ram_addr, 16'h0020);
    chk_val("l3_ack2", b_cpu_ack, 1'b0);
    @(negedge clk);
    chk_val("l3_addr3", b_ram_addr, 16'h0020);
    chk_val("l3_ack3", b_cpu_ack, 1'b0);
    b_ram_data_in = 16'h00AA;
    @(negedge clk);
    chk_val("l3_ack4", b_cpu_ack, 1'b1);
    chk_val("l3_rdata", b_cpu_rdata, 16'h00AA);
    chk_val("l3_addr_done", b_ram_addr, 16'h0000);
    b_cpu_req = 1'b0; b_ram_data_in = 16'h0077;
    @(negedge clk);
    chk_val("l3_ack_pulse", b_cpu_ack, 1'b0);
    chk_val("l3_rdata_hold", b_cpu_rdata, 16'h00AA);
    chk_val("l3_idle", b_busy, 1'b0);

    // Reset during the ACCESS cycle of a cpu write
    a_cpu_addr = 16'h0030; a_cpu_wdata = 16'h5A5A; a_cpu_write_en = 1'b1; a_cpu_req = 1'b1;
    @(negedge clk);
    chk_val("ab_we", a_ram_write_en, 1'b1);
    reset = 1'b1;
    @(negedge clk);
    chk_val("ab_we_drop", a_ram_write_en, 1'b0);
    chk_val("ab_no_ack", {a_cpu_ack, a_aux_ack}, 2'b00);
    chk_val("ab_busy", a_busy, 1'b0);
    chk_val("ab_rdata", {a_cpu_rdata, a_aux_rdata}, 32'h0);
    reset = 1'b0; a_cpu_req = 1'b0; a_cpu_write_en = 1'b0;
    @(negedge clk);
    chk_val("ab_no_ack_late", a_cpu_ack, 1'b0);
    a_cpu_addr = 16'h0010; a_cpu_req = 1'b1;
    wait_ack_a(who);
    chk_val("ab_next_ack", who, 0);
    chk_val("ab_next_rdata", a_cpu_rdata, 16'hBEEF);
    a_cpu_req = 1'b0;
    @(negedge clk);

    // Correct requester: drop req in the ack cycle -> one access
    n = 0;
    a_cpu_req = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (a_cpu_ack) begin
        n++;
        a_cpu_req = 1'b0;
      end
    end
    chk_val("proto_one_ack", n, 1);

    // Requester holds req one extra cycle -> IDLE starts a second access
    n = 0;
    drop_at = 99;
    a_cpu_req = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (i == drop_at) a_cpu_req = 1'b0;
      if (a_cpu_ack) begin
        n++;
        if (n == 1) drop_at = i + 2;
      end
    end
    a_cpu_req = 1'b0;
    chk_val("proto_two_acks", n, 2);

    $display("CHECKS %0d ERRORS %0d", check_cnt, err_cnt);
    $finish;
  end

endmodule
